// File: rtl/nco_clk_gen.sv
// Multi-channel phase-accumulator clock-enable generator with a 2-state config port.
// Each channel produces wrap ticks, a ~50% square clock and a settle-based "locked" flag.
//
// state | meaning
// IDLE  | cfg_ready high, waiting for a config handshake
// APPLY | latched config written into its target channel, cfg_ready low
module nco_clk_gen #(
  parameter int                NUM_CH      = 4,
  parameter int                ACC_W       = 32,
  parameter logic [ACC_W-1:0]  DEFAULT_INC = '0,
  parameter logic [NUM_CH-1:0] EN_RST      = '0,
  parameter int                SETTLE_CYC  = 16,
  localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] locked
);

  typedef enum logic {IDLE, APPLY} state_t;

  localparam logic [15:0] SETTLE = 16'(SETTLE_CYC);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q;
  logic [ACC_W-1:0]  new_inc_q;
  logic              new_en_q;
  logic              handshake;
  logic              ch_ok;
  logic              apply;

  logic [ACC_W-1:0]  acc_q   [NUM_CH];
  logic [ACC_W-1:0]  inc_q   [NUM_CH];
  logic [NUM_CH-1:0] en_q;
  logic [15:0]       cnt_q   [NUM_CH];
  logic [15:0]       cnt_nxt [NUM_CH];
  logic [ACC_W:0]    sum     [NUM_CH];
  logic [NUM_CH-1:0] run;

  assign handshake = (state_q == IDLE) && cfg_valid && cfg_ready;
  assign ch_ok     = (32'(ch_q) < NUM_CH);
  assign apply     = (state_q == APPLY) && ch_ok;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cfg_ready is registered so no cfg_* input reaches an output combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cfg_ready <= 1'b0;
      ch_q      <= '0;
      new_inc_q <= '0;
      new_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_ready <= (state_d == IDLE);
      if (handshake) begin
        ch_q      <= cfg_ch;
        new_inc_q <= cfg_inc;
        new_en_q  <= cfg_en;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sum[c]     = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
      run[c]     = en_q[c] && (inc_q[c] != '0);
      cnt_nxt[c] = (cnt_q[c] == SETTLE) ? cnt_q[c] : cnt_q[c] + 16'd1;
    end
  end

  // APPLY on the target takes priority over a wrap in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        inc_q[c] <= DEFAULT_INC;
        cnt_q[c] <= '0;
      end
      en_q    <= EN_RST;
      tick    <= '0;
      clk_out <= '0;
      locked  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (apply && (ch_q == CH_W'(c))) begin
          inc_q[c]   <= new_inc_q;
          en_q[c]    <= new_en_q;
          acc_q[c]   <= '0;
          cnt_q[c]   <= '0;
          tick[c]    <= 1'b0;
          clk_out[c] <= 1'b0;
          locked[c]  <= 1'b0;
        end else if (run[c]) begin
          acc_q[c]   <= sum[c][ACC_W-1:0];
          tick[c]    <= sum[c][ACC_W];
          clk_out[c] <= sum[c][ACC_W-1];
          cnt_q[c]   <= cnt_nxt[c];
          locked[c]  <= (cnt_nxt[c] == SETTLE);
        end else begin
          tick[c]    <= 1'b0;
          cnt_q[c]   <= '0;
          locked[c]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_nco_clk_gen.sv
// Bench for nco_clk_gen: per-cycle comparison against an arithmetic phase model,
// plus hand-computed tick/clock/lock patterns for the directed scenarios.
module tb_nco_clk_gen;

  localparam int NUM_CH = 4;
  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_inc = '0;
  logic       cfg_en = 1'b0;
  logic [3:0] tick, clk_out, locked;

  int checks = 0;
  int errors = 0;

  nco_clk_gen #(
    .NUM_CH(NUM_CH), .ACC_W(8), .DEFAULT_INC(8'd0), .EN_RST(4'b0000), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .cfg_en(cfg_en), .tick(tick), .clk_out(clk_out), .locked(locked)
  );

  always #5 clk = ~clk;

  // Model: a channel's phase is (running cycles since last apply) * inc, mod 256.
  bit m_valid = 1'b0;
  bit m_ready, m_apply, m_ap_en;
  int m_ap_ch, m_ap_inc;
  int m_n[NUM_CH], m_inc[NUM_CH];
  bit m_en[NUM_CH], m_tick[NUM_CH];

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_ready = 1'b0;
      m_apply = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_n[c] = 0; m_inc[c] = 0; m_en[c] = 1'b0; m_tick[c] = 1'b0;
      end
    end else if (m_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_apply && m_ap_ch == c) begin
          m_inc[c] = m_ap_inc; m_en[c] = m_ap_en; m_n[c] = 0; m_tick[c] = 1'b0;
        end else if (m_en[c] && m_inc[c] != 0) begin
          m_n[c]++;
          m_tick[c] = ((m_n[c] * m_inc[c]) / 256) != (((m_n[c] - 1) * m_inc[c]) / 256);
        end else begin
          m_tick[c] = 1'b0;
        end
      end
      m_apply = m_ready && cfg_valid;
      if (m_apply) begin
        m_ap_ch = int'(cfg_ch); m_ap_inc = int'(cfg_inc); m_ap_en = cfg_en;
      end
      m_ready = !m_apply;
    end
  end

  logic [3:0] e_tick, e_clk, e_lock;
  always @(negedge clk) begin
    if (m_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        e_tick[c] = m_tick[c];
        e_clk[c]  = ((m_n[c] * m_inc[c]) % 256) >= 128;
        e_lock[c] = m_n[c] >= SETTLE;
      end
      checks++;
      if ({tick, clk_out, locked, cfg_ready} !== {e_tick, e_clk, e_lock, m_ready}) begin
        errors++;
        $display("FAIL model_cmp t=%0t got tick=%b clk_out=%b locked=%b ready=%b exp tick=%b clk_out=%b locked=%b ready=%b",
                 $time, tick, clk_out, locked, cfg_ready, e_tick, e_clk, e_lock, m_ready);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Returns in the APPLY cycle (the handshake edge has just passed).
  task automatic do_cfg(input logic [1:0] ch, input logic [7:0] inc, input logic en);
    int w = 0;
    while (!cfg_ready && w < 8) begin step(); w++; end
    chk("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_inc = inc; cfg_en = en;
    step();
    cfg_valid = 1'b0;
  endtask

  logic [11:0] v_tick, v_clk, v_lock;
  logic [7:0]  w_tick, w_lock;
  int pos[$];
  int cnt, w;
  bit b2b, prev;

  initial begin
    // 1: reset for 3 cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tick", {28'd0, tick}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", {31'd0, cfg_ready}, 32'd1);
    chk("post_rst_outs", {20'd0, tick, clk_out, locked}, 32'd0);

    // 2: ch0 inc=64
    do_cfg(2'd0, 8'd64, 1'b1);
    chk("t2_ready_low", {31'd0, cfg_ready}, 32'd0);
    step();
    for (int k = 0; k < 12; k++) begin
      step();
      v_tick[k] = tick[0]; v_clk[k] = clk_out[0]; v_lock[k] = locked[0];
    end
    chk("t2_tick_pat", {20'd0, v_tick}, {20'd0, 12'b1000_1000_1000});
    chk("t2_clk_pat",  {20'd0, v_clk},  {20'd0, 12'b0110_0110_0110});
    chk("t2_lock_pat", {20'd0, v_lock}, {20'd0, 12'b1111_1111_1000});

    // 3: ch2 inc=200, ch1 inc=3
    do_cfg(2'd2, 8'd200, 1'b1);
    do_cfg(2'd1, 8'd3, 1'b1);
    step();
    b2b = 1'b0; prev = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (tick[1]) pos.push_back(k);
      if (tick[2] && prev) b2b = 1'b1;
      prev = tick[2];
    end
    cnt = 0;
    foreach (pos[i]) if (pos[i] <= 256) cnt++;
    chk("t3_ch1_count", cnt, 3);
    if (pos.size() >= 3) begin
      chk("t3_gap0", pos[1] - pos[0], 85);
      chk("t3_gap1", pos[2] - pos[1], 85);
      chk("t3_pos2", pos[2], 256);
    end else begin
      chk("t3_pos_count", pos.size(), 3);
    end
    chk("t3_ch2_b2b", {31'd0, b2b}, 32'd1);

    // 4: reprogram ch0 so APPLY lands on its due wrap
    w = 0;
    while (!(cfg_ready && (m_n[0] % 4 == 2)) && w < 20) begin step(); w++; end
    chk("t4_align", {31'd0, cfg_ready}, 32'd1);
    chk("t4_locked_before", {31'd0, locked[0]}, 32'd1);
    do_cfg(2'd0, 8'd128, 1'b1);
    step();
    chk("t4_tick_suppressed", {31'd0, tick[0]}, 32'd0);
    chk("t4_locked_drop", {31'd0, locked[0]}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      w_tick[k] = tick[0]; w_lock[k] = locked[0];
    end
    chk("t4_tick_pat", {24'd0, w_tick}, {24'd0, 8'b1010_1010});
    chk("t4_lock_pat", {24'd0, w_lock}, {24'd0, 8'b1111_1000});

    // 5: en=0 on ch2, inc=0 on ch1
    do_cfg(2'd2, 8'd200, 1'b0);
    do_cfg(2'd1, 8'd0, 1'b1);
    step();
    cnt = 0; b2b = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tick[0]) cnt++;
      if (tick[2:1] != 2'b00 || locked[2:1] != 2'b00 || clk_out[2:1] != 2'b00) b2b = 1'b1;
    end
    chk("t5_ch0_ticks", cnt, 10);
    chk("t5_halted_quiet", {31'd0, b2b}, 32'd0);

    // random config traffic
    for (int k = 0; k < 400; k++) begin
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       cfg_inc = 8'd0;
        1:       cfg_inc = 8'($urandom_range(1, 8));
        2:       cfg_inc = 8'($urandom_range(128, 255));
        default: cfg_inc = 8'($urandom_range(1, 255));
      endcase
      cfg_en = ($urandom_range(0, 4) != 0);
      step();
    end
    cfg_valid = 1'b0;

    // 6: reset while running, then reset during APPLY
    rst = 1'b1;
    step();
    chk("t6_rst_run", {19'd0, tick, clk_out, locked, cfg_ready}, 32'd0);
    rst = 1'b0;
    step();
    do_cfg(2'd0, 8'd64, 1'b1);
    repeat (10) step();
    do_cfg(2'd3, 8'd32, 1'b1);
    rst = 1'b1;
    step();
    chk("t6_rst_apply", {19'd0, tick, clk_out, locked, cfg_ready}, 32'd0);
    rst = 1'b0;
    b2b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (tick != 4'd0 || locked != 4'd0 || clk_out != 4'd0) b2b = 1'b1;
    end
    chk("t6_cfg_dropped", {31'd0, b2b}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
